// File: rtl/seq_mult16.sv
// seq_mult16: iterative shift-add 16x16 multiplier driving an external shared adder
//   Ports: clk, rst_n (async, active-low)
//          start_i, a_i, b_i           operation request and operands
//          signed_op_i                 two's-complement request (SEQ_MULT_SIGNED_EN only)
//          busy_o, done_o, product_o   handshake and 32-bit result
//          add_a_o, add_b_o, add_cin_o operands driven into the shared adder
//          add_sum_i, add_cout_i       combinational adder result
//   Build option: define SEQ_MULT_SIGNED_EN to add signed operation (NEG_* states).
module seq_mult16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_op_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic [WIDTH-1:0]   add_a_o,
    output logic [WIDTH-1:0]   add_b_o,
    output logic               add_cin_o,
    input  logic [WIDTH-1:0]   add_sum_i,
    input  logic               add_cout_i
);
`ifdef SEQ_MULT_SIGNED_EN
    typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, RUN, NEG_LO, NEG_HI, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 accept;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 neg_res_q, neg_res_d, carry_q, carry_d, neg_a, neg_b;
    assign neg_a = signed_op_i & a_i[WIDTH-1];
    assign neg_b = signed_op_i & b_i[WIDTH-1];
`endif
    assign accept    = start_i && (state_q == IDLE || state_q == DONE);
    assign busy_o    = !(state_q == IDLE || state_q == DONE);
    assign done_o    = state_q == DONE;
    assign product_o = product_q;
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        add_a_o   = '0;
        add_b_o   = '0;
        add_cin_o = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        neg_res_d = neg_res_q;
        carry_d   = carry_q;
`endif
        case (state_q)
            RUN: begin
                add_a_o = hi_q;
                add_b_o = lo_q[0] ? mcand_q : '0;
                {hi_d, lo_d} = {add_cout_i, add_sum_i, lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1))
`ifdef SEQ_MULT_SIGNED_EN
                    state_d = neg_res_q ? NEG_LO : DONE;
`else
                    state_d = DONE;
`endif
            end
`ifdef SEQ_MULT_SIGNED_EN
            // Operand magnitudes: lo still holds b here, so its MSB is b's sign.
            NEG_A: begin
                add_a_o   = ~mcand_q;
                add_cin_o = 1'b1;
                mcand_d   = add_sum_i;
                state_d   = lo_q[WIDTH-1] ? NEG_B : RUN;
            end
            NEG_B: begin
                add_a_o   = ~lo_q;
                add_cin_o = 1'b1;
                lo_d      = add_sum_i;
                state_d   = RUN;
            end
            // 32-bit negate in two halves; the low-half carry feeds the high half.
            NEG_LO: begin
                add_a_o   = ~lo_q;
                add_cin_o = 1'b1;
                lo_d      = add_sum_i;
                carry_d   = add_cout_i;
                state_d   = NEG_HI;
            end
            NEG_HI: begin
                add_a_o   = ~hi_q;
                add_cin_o = carry_q;
                hi_d      = add_sum_i;
                state_d   = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            mcand_d = a_i;
            lo_d    = b_i;
            hi_d    = '0;
            cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg_res_d = neg_a ^ neg_b;
            state_d   = neg_a ? NEG_A : neg_b ? NEG_B : RUN;
`else
            state_d   = RUN;
`endif
        end
        product_d = (state_d == DONE) ? {hi_d, lo_d} : product_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
`ifdef SEQ_MULT_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res_q <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            carry_q   <= carry_d;
        end
    end
`endif
endmodule

// File: tb/tb_seq_mult16.sv
// tb_seq_mult16: randomized scoreboard bench for seq_mult16 with a behavioural adder
module tb_seq_mult16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] a_i = '0, b_i = '0;
    logic        signed_op_i = 1'b0;
    logic        busy_o, done_o, add_cin_o, add_cout_i;
    logic [31:0] product_o;
    logic [15:0] add_a_o, add_b_o, add_sum_i;

    seq_mult16 dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_op_i(signed_op_i),
`endif
        .busy_o(busy_o), .done_o(done_o), .product_o(product_o),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_cin_o(add_cin_o),
        .add_sum_i(add_sum_i), .add_cout_i(add_cout_i)
    );

    assign {add_cout_i, add_sum_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {16'd0, add_cin_o};

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] p; int c; } exp_t;
    exp_t        q[$];
    int          checks = 0, failures = 0;
    int          last_issue = 0, next_free = 0;
    logic [31:0] last_prod = '0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", n, got, want, cyc);
        end
    endtask

    // Reference: exact product plus cycle count (one extra per sign fix-up step).
    task automatic drive(input logic s, input logic [15:0] x, input logic [15:0] y, input logic sg);
        logic        sa, sb;
        logic [31:0] p;
        int          lat;
        @(negedge clk);
        start_i = s; a_i = x; b_i = y; signed_op_i = sg;
        if (s && rst_n && cyc >= next_free) begin
`ifdef SEQ_MULT_SIGNED_EN
            sa = sg & x[15];
            sb = sg & y[15];
            p  = sg ? 32'($signed(x) * $signed(y)) : 32'(x) * 32'(y);
`else
            sa = 1'b0;
            sb = 1'b0;
            p  = 32'(x) * 32'(y);
`endif
            lat = 17 + int'(sa) + int'(sb) + ((sa ^ sb) ? 2 : 0);
            q.push_back('{p, cyc + lat});
            last_issue = cyc;
            next_free  = cyc + lat;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    function automatic logic [15:0] rnd();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'(($urandom_range(0, 1) == 1) ? 1 : 16'h7FFF);
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic mon();
        logic be, ed;
        exp_t e;
        ed = q.size() > 0 && q[0].c == cyc;
        chk("done", {31'd0, done_o}, {31'd0, ed});
        if (ed) begin
            e = q.pop_front();
            chk("product", product_o, e.p);
            last_prod = e.p;
        end else chk("product_hold", product_o, last_prod);
        be = cyc > last_issue && cyc < next_free;
        chk("busy", {31'd0, busy_o}, {31'd0, be});
        if (!be) begin
            chk("adder_ab_idle", {add_a_o, add_b_o}, 32'd0);
            chk("adder_cin_idle", {31'd0, add_cin_o}, 32'd0);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 mon();
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, add_cin_o, add_a_o | add_b_o, 13'd0}, 32'd0);
        chk("reset_product", product_o, 32'd0);
        rst_n = 1'b1;
        idle(2);
        drive(1'b1, 16'd3, 16'd5, 1'b0);
        idle(20);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(20);
        // start held high while busy must be ignored
        for (int i = 0; i < 12; i++) drive(1'b1, 16'h1234, 16'h0000, 1'b0);
        idle(10);
        // second start lands exactly in the DONE cycle
        drive(1'b1, 16'd3, 16'd5, 1'b0);
        for (int k = 0; k < 40 && cyc + 1 < next_free; k++) drive(1'b0, 16'h0, 16'h0, 1'b0);
        drive(1'b1, 16'd7, 16'd9, 1'b0);
        idle(20);
        // async abort mid-run
        drive(1'b1, 16'h1234, 16'h5678, 1'b0);
        idle(8);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        next_free = cyc;
        last_prod = '0;
        #1;
        chk("abort_outputs", {busy_o, done_o, add_cin_o, add_a_o | add_b_o, 13'd0}, 32'd0);
        chk("abort_product", product_o, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(25);
`ifdef SEQ_MULT_SIGNED_EN
        drive(1'b1, 16'hFFFD, 16'd5, 1'b1);
        idle(22);
        drive(1'b1, 16'h8000, 16'h8000, 1'b1);
        idle(22);
        drive(1'b1, 16'h8000, 16'h0001, 1'b1);
        idle(22);
`endif
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 2) == 0, rnd(), rnd(), 1'($urandom_range(0, 1)));
        idle(25);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
